mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter between the CPU memory interface and a DMA/loader port. Sits between the CPU controller/datapath (`mem_cmd`, address, write data) and the one-cycle-latency RAM. Resolves conflicting accesses each cycle and stalls the losing CPU access. Routes registered read data back to the correct requester.

## Interface
- `ADDR_W`, 9, RAM address width
- `DATA_W`, 16, data width
- `MAX_WAIT`, 3, consecutive denied DMA cycles before DMA is forced to win (used only with `MEM_ARB_FAIR_EN`); legal range 1..15
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high
- `cpu_mem_cmd`  in  2  00 none, 01 write, 11 read, 10 illegal (treated as none)
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_rdata`  out  DATA_W  read data to CPU
- `cpu_stall`  out  1  CPU access not granted this cycle; CPU holds request
- `dma_req`  in  1  DMA access request
- `dma_we`  in  1  1 write, 0 read
- `dma_addr`  in  ADDR_W  DMA address
- `dma_wdata`  in  DATA_W  DMA write data
- `dma_gnt`  out  1  DMA access accepted this cycle
- `dma_rdata`  out  DATA_W  read data to DMA
- `dma_rvalid`  out  1  `dma_rdata` valid, one cycle after a granted DMA read
- `ram_addr`  out  ADDR_W  RAM address
- `ram_wdata`  out  DATA_W  RAM write data
- `ram_we`  out  1  RAM write enable
- `ram_rdata`  in  DATA_W  RAM read data, valid one cycle after address

## Operation
- **Requests.** CPU requests when `cpu_mem_cmd` is 01 or 11. DMA requests when `dma_req`=1.
- **Grant decision.** Combinational, same cycle as the requests.
  - Only one requester: it wins.
  - Both requesting: CPU wins, except when the fairness counter equals `MAX_WAIT`, in which case DMA wins.
- **Winner drives the RAM.** `ram_addr`, `ram_wdata` and `ram_we` come from the winner.
  - `ram_we` = CPU cmd 01, or DMA with `dma_we`=1.
  - With no winner: `ram_we`=0 and `ram_addr` holds the last value.
- **Stall/grant outputs.**
  - `cpu_stall`=1 iff the CPU requests and DMA wins.
  - `dma_gnt`=1 iff DMA wins.
- **Read owner register** `rd_owner` ∈ {NONE, CPU, DMA}. Loaded each cycle with the winner if the access is a read, else NONE.
- **Read data routing.**
  - `cpu_rdata` = `ram_rdata` passthrough at all times; the CPU samples it after IF1/IF2 or LDR, one cycle after a granted read.
  - `dma_rdata` = `ram_rdata`; `dma_rvalid` = (`rd_owner`==DMA).
- **Fairness counter** `wait_cnt`, 4 bits:
  - increments when `dma_req` && !`dma_gnt`, saturating at `MAX_WAIT`;
  - clears when `dma_gnt`=1 or `dma_req`=0.
- **Write data.** Writes are taken in the grant cycle; no write response.

## Timing
- **Reset values:** `rd_owner`=NONE, `wait_cnt`=0, `ram_addr`=0, `dma_rvalid`=0. Combinational outputs follow from inputs, so with no requests `cpu_stall`=0, `dma_gnt`=0, `ram_we`=0.
- **Grant latency:** 0 cycles.
- **Read latency:** 1 cycle from grant to data/`dma_rvalid`.
- **Throughput:** one access per cycle; back-to-back grants to either side are allowed.
- **Simultaneous request behaviour:**
  - With `MAX_WAIT`=3 and the CPU requesting continuously, DMA loses 3 cycles and wins on the 4th.
  - `wait_cnt` then clears.
- **Stalled CPU:** while `cpu_stall`=1 the CPU must keep `cpu_mem_cmd`/`cpu_addr` stable.
  - The arbiter does not latch CPU requests.
- **Illegal cmd:** `cpu_mem_cmd`=10 is no request, and no stall is asserted.
- **Reset mid-read:** `rd_owner` clears immediately (asynchronous), so no `dma_rvalid` is produced for the in-flight read.
- **DMA dropping `dma_req` while denied:** no state is kept except that `wait_cnt` clears.

## Configuration
- **`MEM_ARB_FAIR_EN` defined:** fairness counter present; behaviour as above.
- **`MEM_ARB_FAIR_EN` undefined:** strict CPU priority.
  - `wait_cnt` is not implemented and `MAX_WAIT` is ignored.
  - DMA wins only in cycles with no CPU request.

## Test plan
- Reset, idle → `cpu_stall`=0, `dma_gnt`=0, `ram_we`=0, `dma_rvalid`=0, `ram_addr`=0.
- CPU read addr 0x005 (cmd 11), RAM holds 0xBEEF → `ram_addr`=0x005 in the same cycle; next cycle `cpu_rdata`=0xBEEF, `dma_rvalid`=0.
- DMA write 0x1234 to 0x010, no CPU request → `dma_gnt`=1, `ram_we`=1, `ram_addr`=0x010, `ram_wdata`=0x1234.
- CPU cmd 11 held and `dma_req` held, `MAX_WAIT`=3, `MEM_ARB_FAIR_EN` defined → `dma_gnt` pattern 0,0,0,1 repeating. `cpu_stall`=1 only in the 4th cycle, and `dma_rvalid`=1 in the following cycle for a DMA read.
- Same stimulus with the macro undefined → `dma_gnt` stays 0 and `cpu_stall` stays 0 for 20 cycles.
- DMA read granted, `reset` asserted the next half-cycle → `dma_rvalid` stays 0; after reset release all outputs are at their reset values.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the one-cycle RAM and mem_arbiter.
// The arbiter uses the slave modport; requesters plus RAM sit on the master side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [1:0]        cpu_mem_cmd;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_mem_cmd, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  ram_rdata,
        output cpu_rdata, cpu_stall,
        output dma_gnt, dma_rdata, dma_rvalid,
        output ram_addr, ram_wdata, ram_we
    );

    modport master (
        output cpu_mem_cmd, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output ram_rdata,
        input  cpu_rdata, cpu_stall,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: CPU has priority, DMA wins idle cycles. Define
// MEM_ARB_FAIR_EN to let DMA force a win after MAX_WAIT consecutive denials.
module mem_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
        $error("mem_arbiter: MAX_WAIT must be in 1..15");
    end

    owner_e            rd_owner_q, rd_owner_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;

    logic cpu_wr, cpu_rd, cpu_req;
    logic dma_win, cpu_win;

    // Command 10 decodes to neither read nor write, so it never requests or stalls.
    assign cpu_wr  = (bus.cpu_mem_cmd == 2'b01);
    assign cpu_rd  = (bus.cpu_mem_cmd == 2'b11);
    assign cpu_req = cpu_wr || cpu_rd;

`ifdef MEM_ARB_FAIR_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       dma_force;

    assign dma_force = (wait_cnt_q == 4'(MAX_WAIT));
    assign dma_win   = bus.dma_req && (!cpu_req || dma_force);

    // A denial only happens below MAX_WAIT, so the increment saturates by construction.
    always_comb begin
        wait_cnt_d = 4'd0;
        if (bus.dma_req && !dma_win) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign dma_win = bus.dma_req && !cpu_req;
`endif

    assign cpu_win = cpu_req && !dma_win;

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_wdata  = '0;
        ram_we     = 1'b0;
        rd_owner_d = OWN_NONE;
        if (dma_win) begin
            ram_addr_d = bus.dma_addr;
            ram_wdata  = bus.dma_wdata;
            ram_we     = bus.dma_we;
            rd_owner_d = bus.dma_we ? OWN_NONE : OWN_DMA;
        end else if (cpu_win) begin
            ram_addr_d = bus.cpu_addr;
            ram_wdata  = bus.cpu_wdata;
            ram_we     = cpu_wr;
            rd_owner_d = cpu_rd ? OWN_CPU : OWN_NONE;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner_q <= OWN_NONE;
            ram_addr_q <= '0;
        end else begin
            rd_owner_q <= rd_owner_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    assign bus.ram_addr   = ram_addr_d;
    assign bus.ram_wdata  = ram_wdata;
    assign bus.ram_we     = ram_we;

    assign bus.cpu_stall  = cpu_req && dma_win;
    assign bus.dma_gnt    = dma_win;

    assign bus.cpu_rdata  = bus.ram_rdata;
    assign bus.dma_rdata  = bus.ram_rdata;
    assign bus.dma_rvalid = (rd_owner_q == OWN_DMA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural model predicts every cycle,
// a negedge monitor pops and compares; works with or without MEM_ARB_FAIR_EN.
module tb_mem_arbiter;

    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 16;
    localparam int MAX_WAIT = 3;
    localparam int DEPTH    = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM attached to the DUT, plus the reference copy the model updates.
    logic [DATA_W-1:0] ram_mem [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram_mem[bus.ram_addr];
    end

    typedef struct {
        bit                gnt;
        bit                stall;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        bit                rvalid;
        bit                chk_cpu;
        logic [DATA_W-1:0] cpu_data;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] dma_rd_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int gnt_seen = 0;
    bit mon_en   = 1'b0;

    // Model state: who read last cycle and what they should see, DMA denial run, last address.
    int                m_owner;
    logic [DATA_W-1:0] m_data;
    int                m_wait;
    logic [ADDR_W-1:0] m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_inputs(input logic [1:0] cmd, input logic [ADDR_W-1:0] ca,
                              input logic [DATA_W-1:0] cw, input bit dreq, input bit dwe,
                              input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dw);
        bus.cpu_mem_cmd = cmd;
        bus.cpu_addr    = ca;
        bus.cpu_wdata   = cw;
        bus.dma_req     = dreq;
        bus.dma_we      = dwe;
        bus.dma_addr    = da;
        bus.dma_wdata   = dw;
    endtask

    task automatic drive_cycle(input logic [1:0] cmd, input logic [ADDR_W-1:0] ca,
                               input logic [DATA_W-1:0] cw, input bit dreq, input bit dwe,
                               input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dw);
        exp_t e;
        bit   creq, dwin, cwin;
        @(posedge clk);
        #1;
        set_inputs(cmd, ca, cw, dreq, dwe, da, dw);
        creq = (cmd == 2'b01) || (cmd == 2'b11);
`ifdef MEM_ARB_FAIR_EN
        dwin   = dreq && (!creq || m_wait == MAX_WAIT);
        m_wait = (dreq && !dwin) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
`else
        dwin = dreq && !creq;
`endif
        cwin       = creq && !dwin;
        e.gnt      = dwin;
        e.stall    = creq && dwin;
        e.rvalid   = (m_owner == 2);
        e.chk_cpu  = (m_owner == 1);
        e.cpu_data = m_data;
        if (dwin) begin
            e.addr = da; e.we = dwe; e.wdata = dw;
        end else if (cwin) begin
            e.addr = ca; e.we = (cmd == 2'b01); e.wdata = cw;
        end else begin
            e.addr = m_last; e.we = 1'b0; e.wdata = '0;
        end
        m_last  = e.addr;
        m_owner = 0;
        if (dwin && !dwe) begin
            m_owner = 2;
            m_data  = ref_mem[da];
            dma_rd_q.push_back(ref_mem[da]);
        end
        if (cwin && cmd == 2'b11) begin
            m_owner = 1;
            m_data  = ref_mem[ca];
        end
        if (e.we) ref_mem[e.addr] = e.wdata;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycle();
        drive_cycle(2'b00, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("dma_gnt",    32'(bus.dma_gnt),    32'(mon_e.gnt));
                check("cpu_stall",  32'(bus.cpu_stall),  32'(mon_e.stall));
                check("ram_we",     32'(bus.ram_we),     32'(mon_e.we));
                check("ram_addr",   32'(bus.ram_addr),   32'(mon_e.addr));
                check("dma_rvalid", 32'(bus.dma_rvalid), 32'(mon_e.rvalid));
                if (mon_e.we)      check("ram_wdata", 32'(bus.ram_wdata), 32'(mon_e.wdata));
                if (mon_e.chk_cpu) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(mon_e.cpu_data));
            end
            if (bus.dma_rvalid === 1'b1) begin
                if (dma_rd_q.size() == 0) check("dma_rvalid_unexpected", 32'd1, 32'd0);
                else check("dma_rdata", 32'(bus.dma_rdata), 32'(dma_rd_q.pop_front()));
            end
            if (bus.dma_gnt === 1'b1) gnt_seen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g0;
        int n_hold;
        logic [DATA_W-1:0] v;

        reset = 1'b1;
        set_inputs(2'b00, '0, '0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            v = DATA_W'($urandom);
            ram_mem[i] = v;
            ref_mem[i] = v;
        end
        ram_mem[5] = 16'hBEEF;
        ref_mem[5] = 16'hBEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cpu_stall",  32'(bus.cpu_stall),  32'd0);
        check("reset_dma_gnt",    32'(bus.dma_gnt),    32'd0);
        check("reset_ram_we",     32'(bus.ram_we),     32'd0);
        check("reset_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
        check("reset_ram_addr",   32'(bus.ram_addr),   32'd0);
        reset   = 1'b0;
        m_owner = 0;
        m_data  = '0;
        m_wait  = 0;
        m_last  = '0;
        mon_en  = 1'b1;

        // CPU read of 0x005, then DMA write of 0x1234 to 0x010.
        drive_cycle(2'b11, 9'h005, '0, 1'b0, 1'b0, '0, '0);
        idle_cycle();
        drive_cycle(2'b00, '0, '0, 1'b1, 1'b1, 9'h010, 16'h1234);
        idle_cycle();

        // Both sides held: read by CPU, read by DMA.
        n_hold = 20;
`ifdef MEM_ARB_FAIR_EN
        n_hold = 4 * (MAX_WAIT + 1);
`endif
        g0 = gnt_seen;
        repeat (n_hold) drive_cycle(2'b11, 9'h020, '0, 1'b1, 1'b0, 9'h030, '0);
        idle_cycle();
`ifdef MEM_ARB_FAIR_EN
        check("held_dma_gnt_count", 32'(gnt_seen - g0), 32'(n_hold / (MAX_WAIT + 1)));
`else
        check("held_dma_gnt_count", 32'(gnt_seen - g0), 32'd0);
`endif

        // Illegal command is no request: DMA wins and nothing stalls.
        drive_cycle(2'b10, 9'h040, 16'hAAAA, 1'b1, 1'b0, 9'h041, '0);
        drive_cycle(2'b10, 9'h042, 16'h5555, 1'b0, 1'b0, '0, '0);
        idle_cycle();

        // Randomized traffic on a small address window to force hits and collisions.
        repeat (400) begin
            drive_cycle(2'($urandom_range(0, 3)), 9'($urandom_range(0, 15)), 16'($urandom),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        9'($urandom_range(0, 15)), 16'($urandom));
        end
        idle_cycle();
        idle_cycle();
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("exp_queue_drained", 32'(exp_q.size()),    32'd0);
        check("dma_rd_q_drained",  32'(dma_rd_q.size()), 32'd0);

        // DMA read granted, reset lands half a cycle later: no rvalid may follow.
        @(posedge clk);
        #1;
        set_inputs(2'b00, '0, '0, 1'b1, 1'b0, 9'h0AB, '0);
        #3;
        check("midread_dma_gnt", 32'(bus.dma_gnt), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("midread_rvalid_in_reset", 32'(bus.dma_rvalid), 32'd0);
        set_inputs(2'b00, '0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
        check("post_reset_ram_addr",   32'(bus.ram_addr),   32'd0);
        check("post_reset_cpu_stall",  32'(bus.cpu_stall),  32'd0);
        check("post_reset_dma_gnt",    32'(bus.dma_gnt),    32'd0);
        check("post_reset_ram_we",     32'(bus.ram_we),     32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
